// File: rtl/regadd_result_fifo.sv
// Result FIFO behind the n-bit registered adder.
// Each valid {c_out, sum} result is queued here. A consumer drains the queue at its own rate.
// The head entry falls through to rd_data with no read latency.
// The block also keeps sticky overflow/underflow flags and a saturating count of carry-out results.
// DEPTH must be a power of two and at least 2, so pointer wrap is the natural binary rollover.
module regadd_result_fifo #(
   parameter int n     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [n-1:0]               sum,
   input  logic                       c_out,
   input  logic                       rd_en,
   output logic [n:0]                 rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow,
   output logic [CW-1:0]              carry_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CC_ONE   = CW'(1);

   typedef struct packed {
      logic         c_out;
      logic [n-1:0] sum;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_acc;
   logic          pop;

   // Full and empty are decoded from the registered count.
   // Because of this, no output has a combinational path from the write-side inputs.
   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

   // A write is accepted when full only if a pop frees a slot in the same cycle.
   // A pop is honoured only when an entry is present.
   assign wr_acc = in_valid && (!full || rd_en);
   assign pop    = rd_en && !empty;

   // First-word-fall-through head. The output is held at zero when the FIFO is empty.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Storage array. Its contents are left untouched by reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= {c_out, sum};
   end

   // Pointers, occupancy and status flags.
   // Reset is asynchronous, so it clears these even mid-transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         carry_cnt <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_acc, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (in_valid && full && !rd_en) overflow  <= 1'b1;
         if (rd_en && empty)             underflow <= 1'b1;
         if (wr_acc && c_out && (carry_cnt != '1)) carry_cnt <= carry_cnt + CC_ONE;
      end
   end

endmodule

// File: tb/tb_regadd_result_fifo.sv
// Scoreboard bench for regadd_result_fifo (n=8, DEPTH=4, CW=8).
// Accepted writes queue their expected entry.
// A negedge monitor compares every real pop against the head of that queue.
module tb_regadd_result_fifo;

   localparam int N  = 8;
   localparam int D  = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [N-1:0]  sum = '0;
   logic          c_out = 1'b0;
   logic          rd_en = 1'b0;
   logic [N:0]    rd_data;
   logic          empty, full, overflow, underflow;
   logic [2:0]    count;
   logic [CW-1:0] carry_cnt;

   int checks   = 0;
   int failures = 0;
   int mc       = 0;
   logic [N:0] sb [$];

   regadd_result_fifo #(.n(N), .DEPTH(D), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .c_out(c_out),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
      .count(count), .overflow(overflow), .underflow(underflow),
      .carry_cnt(carry_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus and advance the reference occupancy model.
   task automatic step(input logic iv, input logic [N-1:0] s, input logic co, input logic re);
      bit acc, pp;
      in_valid = iv; sum = s; c_out = co; rd_en = re;
      acc = iv && (mc < D || re);
      pp  = re && (mc > 0);
      if (acc) sb.push_back({co, s});
      mc = mc + int'(acc) - int'(pp);
      @(posedge clk); #1;
   endtask

   // Monitor: every cycle in which the consumer really pops must show the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && rd_en && !empty) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL pop_unexpected: got 0x%0h expected no entry", rd_data);
         end else begin
            chk("pop_data", {23'd0, rd_data}, {23'd0, sb.pop_front()});
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      // reset state
      chk("rst_empty", {31'd0, empty}, 1);
      chk("rst_full", {31'd0, full}, 0);
      chk("rst_count", {29'd0, count}, 0);
      chk("rst_rd_data", {23'd0, rd_data}, 0);
      chk("rst_overflow", {31'd0, overflow}, 0);
      chk("rst_underflow", {31'd0, underflow}, 0);
      chk("rst_carry_cnt", {24'd0, carry_cnt}, 0);
      @(posedge clk); #1;

      // fill the FIFO, then drain it
      step(1, 8'h07, 0, 0);
      step(1, 8'h10, 0, 0);
      step(1, 8'hFF, 1, 0);
      step(1, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);
      chk("fill_count", {29'd0, count}, 4);
      chk("fill_full", {31'd0, full}, 1);
      chk("fill_carry", {24'd0, carry_cnt}, 2);
      chk("fill_head", {23'd0, rd_data}, 32'h007);
      repeat (4) step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("drain_empty", {31'd0, empty}, 1);
      chk("drain_rd_data", {23'd0, rd_data}, 0);

      // overflow while full, then a write and pop in the same cycle while full
      step(1, 8'h01, 0, 0);
      step(1, 8'h02, 0, 0);
      step(1, 8'h03, 0, 0);
      step(1, 8'h04, 0, 0);
      step(1, 8'h55, 0, 0);
      step(0, 8'h00, 0, 0);
      chk("ovf_flag", {31'd0, overflow}, 1);
      chk("ovf_count", {29'd0, count}, 4);
      chk("ovf_head", {23'd0, rd_data}, 32'h001);
      step(1, 8'h66, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("fullrw_count", {29'd0, count}, 4);
      chk("fullrw_head", {23'd0, rd_data}, 32'h002);
      repeat (4) step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("fullrw_empty", {31'd0, empty}, 1);

      // underflow on an empty FIFO, then a write and pop together while empty
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("udf_flag", {31'd0, underflow}, 1);
      chk("udf_count", {29'd0, count}, 0);
      step(1, 8'h21, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("emptyrw_count", {29'd0, count}, 1);
      chk("emptyrw_head", {23'd0, rd_data}, 32'h021);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);

      // pointer wrap-around: values 1..10 passed through one-in/one-out
      step(1, 8'd1, 0, 0);
      for (int v = 2; v <= 10; v++) step(1, 8'(v), 0, 1);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("wrap_empty", {31'd0, empty}, 1);
      chk("wrap_sb_drained", sb.size(), 0);
      chk("carry_held", {24'd0, carry_cnt}, 2);

      // asynchronous reset with entries present and overflow still set
      step(1, 8'h31, 1, 0);
      step(1, 8'h32, 0, 0);
      step(1, 8'h33, 0, 0);
      step(0, 8'h00, 0, 0);
      chk("pre_rst_count", {29'd0, count}, 3);
      chk("pre_rst_ovf", {31'd0, overflow}, 1);
      rst = 1'b1;
      sb.delete();
      mc = 0;
      #1;
      chk("arst_count", {29'd0, count}, 0);
      chk("arst_empty", {31'd0, empty}, 1);
      chk("arst_full", {31'd0, full}, 0);
      chk("arst_rd_data", {23'd0, rd_data}, 0);
      chk("arst_overflow", {31'd0, overflow}, 0);
      chk("arst_underflow", {31'd0, underflow}, 0);
      chk("arst_carry", {24'd0, carry_cnt}, 0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      step(1, 8'h0A, 0, 0);
      step(0, 8'h00, 0, 0);
      chk("post_rst_head", {23'd0, rd_data}, 32'h00A);
      chk("post_rst_count", {29'd0, count}, 1);
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("post_rst_empty", {31'd0, empty}, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
